// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic stream decoder.
// Provides the FSM state encoding and the window-length helper.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sc_state_e;

  localparam int WIN_W_DEF = 8;

  // Window length N = 2^w - 1, one full period of a w-bit maximal LFSR.
  function automatic int win_len(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sc_window_counter.sv
// Valid-sample counter for one decoding window.
// terminal marks the increment that brings the count to N.
module sc_window_counter
  import sc_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  localparam logic [WIN_W-1:0] LAST = WIN_W'(win_len(WIN_W) - 1);

  logic [WIN_W-1:0] count_q;
  logic [WIN_W-1:0] count_d;

  // Next count: clear wins over increment.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + WIN_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = inc && (count_q == LAST);

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter: counts 1s over a 2^WIN_W-1 sample window
// and hands the count to the consumer through a valid/ack handshake.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic [WIN_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ack
);

  sc_state_e        state_q;
  sc_state_e        state_d;
  logic [WIN_W-1:0] ones_q;
  logic [WIN_W-1:0] ones_d;
  logic [WIN_W-1:0] result_q;
  logic [WIN_W-1:0] result_d;
  logic             cnt_clear;
  logic             cnt_inc;
  logic             cnt_terminal;

  // Kept outside the FSM process so terminal never loops back into it.
  assign cnt_inc   = (state_q == ACCUM) && bit_valid && !abort;
  assign cnt_clear = (state_q != ACCUM) || abort;

  sc_window_counter #(.WIN_W(WIN_W)) u_window_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .terminal (cnt_terminal)
  );

  // Next-state, ones accumulator and result capture.
  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        ones_d = '0;
        if (!abort && start) begin
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (abort) begin
          ones_d  = '0;
          state_d = IDLE;
        end else if (bit_valid) begin
          ones_d = ones_q + WIN_W'(bit_in);
          if (cnt_terminal) begin
            result_d = ones_q + WIN_W'(bit_in);
            state_d  = DONE;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DONE: begin
        if (abort || result_ack) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        ones_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ones_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      result_q <= result_d;
    end
  end

  assign busy         = (state_q == ACCUM);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard bench for sc_stream_decoder: a model counts the 1s in each
// driven window and queues the expected count and the cycle it must appear.
module tb_sc_stream_decoder;

  localparam int W = 8;
  localparam int N = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         result_ack = 1'b0;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] result;

  typedef struct packed {
    logic [31:0] val;
    logic [31:0] at;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_result = 0;
  logic rv_prev = 1'b0;

  sc_stream_decoder #(.WIN_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rising result_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1 && rv_prev !== 1'b1) begin
      check("sb_expected_result", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb.size() > 0) begin
        popped = sb.pop_front();
        check("result_value", {24'd0, result}, popped.val);
        check("result_latency", cyc, popped.at);
      end
    end
    rv_prev = result_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // pat: 0 ones, 1 zeros, 2 alternating 1/0, 3 random; gap: 0 none, 1 every third, 2 random.
  task automatic run_window(input int pat, input int gap, input int restart_at);
    int ones = 0;
    int n = 0;
    int slot = 0;
    int busy_low = 0;
    int b;
    bit gap_now;
    step();
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    while (n < N) begin
      step();
      start = 1'b0; bit_valid = 1'b0; bit_in = 1'($urandom % 2);
      if (busy !== 1'b1) busy_low++;
      gap_now = (gap == 1) ? (slot % 3 == 2) : (gap == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      slot++;
      if (!gap_now) begin
        case (pat)
          0: b = 1;
          1: b = 0;
          2: b = (n % 2 == 0) ? 1 : 0;
          default: b = int'($urandom % 2);
        endcase
        bit_valid = 1'b1;
        bit_in = 1'(b);
        ones += b;
        n++;
        if (n == restart_at) start = 1'b1;
        if (n == N) sb.push_back('{32'(ones), 32'(cyc + 1)});
      end
    end
    step();
    start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    check("busy_through_accum", busy_low, 0);
    last_result = ones;
  endtask

  task automatic hold_and_ack(input int hold, input bit with_start);
    repeat (hold) begin
      step();
      bit_valid = 1'b1; bit_in = 1'b1; start = 1'($urandom % 2);
      check("done_hold_valid", result_valid, 1);
      check("done_hold_result", result, last_result);
      check("done_not_busy", busy, 0);
    end
    step();
    bit_valid = 1'b0; start = with_start; result_ack = 1'b1;
    step();
    result_ack = 1'b0; start = 1'b0;
    check("ack_valid_drop", result_valid, 0);
    check("ack_result_kept", result, last_result);
    check("ack_idle_not_busy", busy, 0);
    step();
    check("post_ack_idle", busy, 0);
  endtask

  // Partial window of k ones, then kill=0 abort or kill=1 reset alongside a valid bit.
  task automatic partial(input int k, input int kill);
    step();
    start = 1'b1; bit_valid = 1'b0;
    repeat (k) begin
      step();
      start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
    end
    step();
    bit_valid = 1'b1; bit_in = 1'b1;
    if (kill == 0) abort = 1'b1;
    else rst_n = 1'b0;
    step();
    bit_valid = 1'b0;
    if (kill == 0) begin
      abort = 1'b0;
      check("abort_not_busy", busy, 0);
      check("abort_no_valid", result_valid, 0);
      check("abort_result_kept", result, last_result);
    end else begin
      check("rst_busy", busy, 0);
      check("rst_valid", result_valid, 0);
      check("rst_result", result, 0);
      rst_n = 1'b1;
      last_result = 0;
    end
    repeat (3) step();
    check("killed_stays_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    step();

    run_window(0, 0, -1);
    check("all_ones_255", result, 255);
    hold_and_ack(0, 1'b0);

    run_window(2, 1, -1);
    check("alternating_128", result, 128);
    hold_and_ack(2, 1'b1);

    run_window(1, 0, -1);
    check("all_zeros_0", result, 0);
    hold_and_ack(0, 1'b0);
    run_window(0, 2, -1);
    hold_and_ack(10, 1'b0);

    partial(100, 0);
    run_window(0, 0, -1);
    hold_and_ack(0, 1'b0);

    run_window(3, 2, -1);
    step();
    abort = 1'b1; result_ack = 1'b0;
    step();
    abort = 1'b0;
    check("done_abort_valid", result_valid, 0);
    check("done_abort_result", result, last_result);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("idle_abort_blocks_start", busy, 0);

    partial(50, 1);
    run_window(0, 0, -1);
    hold_and_ack(0, 1'b0);

    run_window(0, 0, 120);
    hold_and_ack(0, 1'b0);

    repeat (3) begin
      run_window(3, 2, -1);
      hold_and_ack($urandom_range(0, 4), 1'($urandom % 2));
    end

    repeat (5) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter: the reading end of the stochastic number generator (LFSR plus comparator) path.
- Counts the 1s in a stochastic bitstream over one full 8-bit LFSR period (255 bits) and returns the binary count through a valid/ack handshake.
- Sits after the stochastic logic network (e.g. on `output_circuit`) and returns the computed probability as an unsigned binary word.

Parameters:
- WIN_W, 8, counter width; window length N = 2^WIN_W - 1 valid bits (255 by default, equal to the LFSR period).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a new window; accepted only in IDLE.
- abort  input  1  cancel the current window or drop a pending result.
- bit_in  input  1  stochastic bitstream sample.
- bit_valid  input  1  bit_in is meaningful this cycle.
- busy  output  1  high in ACCUM.
- result  output  WIN_W  number of 1s counted in the last completed window.
- result_valid  output  1  result is ready; held until acknowledged.
- result_ack  input  1  consumer accepts result.

Behaviour:
- Reset: `rst_n` is sampled low on a clock edge (synchronous, active-low). The block then enters IDLE and clears `busy`, `result`, `result_valid`, the sample counter and the ones counter. Reset overrides every other input, including mid-window and during DONE.
- States:
  - IDLE: `start` -> ACCUM. Ones counter and sample counter are cleared on that edge. A `bit_valid` in the start cycle is not counted.
  - ACCUM (`busy`=1):
    - Each cycle with `bit_valid`=1, the sample counter increments and the ones counter adds `bit_in`.
    - Cycles with `bit_valid`=0 change nothing. Gaps of any length are allowed.
    - On the valid bit that makes the sample count reach N, that bit is included. `result` <= ones + `bit_in`, then -> DONE.
    - `result_valid` rises the cycle after the last valid bit.
  - DONE (`result_valid`=1, `busy`=0):
    - `result` is stable.
    - `result_ack` -> IDLE on the next edge; `result_valid` drops. `result` keeps its value until the next window completes.
    - `bit_valid` and `start` are ignored in DONE.
- Abort:
  - Takes priority over `bit_valid`, `start` and `result_ack`.
  - In ACCUM: -> IDLE, counters cleared, `result` unchanged, no `result_valid`.
  - In DONE: -> IDLE, `result_valid` cleared.
  - In IDLE: no effect, and `start` is blocked that cycle.
- `start` while in ACCUM or DONE: ignored, with no restart.
- `start` and `result_ack` in the same DONE cycle: the block goes to IDLE only. A new `start` is required.
- Width: the ones count is at most N = 2^WIN_W - 1, so it fits in WIN_W bits. No saturation logic is needed.
- Sample counter: WIN_W bits, terminal value N; it never wraps inside a window.
- Latency: `result_valid` comes 1 cycle after the N-th valid bit. Minimum window is N+1 cycles from `start` to `result_valid`.

Decomposition:
- Shared package `sc_pkg`:
  - state enum: IDLE, ACCUM, DONE
  - default WIN_W = 8
  - localparam function for N = 2^WIN_W - 1
- Sub-module `sc_window_counter`:
  - WIN_W-bit valid-sample counter
  - inputs: clear, inc
  - output: terminal flag, asserted when count == N-1 and inc is high
- The FSM and the ones accumulator stay in `sc_stream_decoder`.

Test Plan:
- Reset, then `start`, then 255 valid bits all 1 -> `result`=255, `result_valid`=1 exactly one cycle after the 255th bit; `result_ack` -> `result_valid`=0 next cycle, `result` stays 255.
- Alternating bits 1,0,1,... over 255 valid samples with `bit_valid` low every third cycle -> `result`=128, `busy` high throughout ACCUM, gaps are not counted.
- All-zero stream -> `result`=0. Then a second window of 255 ones with no ack until 10 cycles after completion -> `result_valid` held for those 10 cycles and `result` stable at 255; extra `bit_valid` and `start` pulses during DONE are ignored.
- `start`, 100 ones, then `abort` asserted together with `bit_valid`=1 -> IDLE next cycle, `busy`=0, no `result_valid`, previous `result` retained. A new window of 255 ones then gives 255, with no carry-over.
- `rst_n`=0 for one cycle mid-ACCUM (after 50 bits), then `start` and 255 ones -> during reset all outputs are 0, and the final `result`=255.
- `start` pulsed again at sample 120 of a 255-one window -> ignored, and `result`=255 appears at the normal cycle.
